data_write: RTL and testbench

DATA_WRITE -- requirements
Module: data_write

---
 rtl/data_write_pkg.sv | 46 ++++
 rtl/data_write_burst_addr_gen.sv | 38 +++
 rtl/data_write.sv | 136 +++++++++++++
 tb/tb_data_write.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_write_pkg.sv
// Shared parameter package for the write and read data paths.
// Holds the bus widths, the burst-type and response encodings, the FSM
// state type, and a helper that builds the byte-lane mask for one beat.
package data_write_pkg;

    localparam int ADD_ID_WIDTH = 4;
    localparam int ADD_WIDTH    = 32;
    localparam int DATA_WIDTH   = 32;   // multiple of 8
    localparam int BURST_LEN    = 8;
    localparam int BURST_SIZE   = 3;
    localparam int BURST_TYPE   = 2;

    localparam int STRB_WIDTH   = DATA_WIDTH / 8;
    localparam int LANE_W       = $clog2(STRB_WIDTH);

    typedef enum logic [BURST_TYPE-1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_RESP
    } state_t;

    // Enables the 2**size bytes of a beat, starting at the lane offset of the
    // beat address rounded down to the transfer size.
    function automatic logic [STRB_WIDTH-1:0] lane_mask(
        input logic [LANE_W-1:0]     lane,
        input logic [BURST_SIZE-1:0] size
    );
        int unsigned nbytes;
        int unsigned offset;
        nbytes = 32'd1 << size;
        if (nbytes >= STRB_WIDTH) return '1;
        offset = 32'(lane) & ~(nbytes - 32'd1);
        return STRB_WIDTH'(((32'd1 << nbytes) - 32'd1) << offset);
    endfunction

endpackage

// File: rtl/data_write_burst_addr_gen.sv
// burst_addr_gen: combinational next-address calculator for one burst beat.
// Shared by the write and read data paths.
//   addr      current beat byte address
//   len       burst length minus one
//   size      log2 of bytes per beat
//   burst     FIXED / INCR / WRAP (reserved encoding behaves as INCR)
//   next_addr address of the following beat
module burst_addr_gen
    import data_write_pkg::*;
(
    input  logic [ADD_WIDTH-1:0]  addr,
    input  logic [BURST_LEN-1:0]  len,
    input  logic [BURST_SIZE-1:0] size,
    input  logic [BURST_TYPE-1:0] burst,
    output logic [ADD_WIDTH-1:0]  next_addr
);

    logic [ADD_WIDTH-1:0] step_bytes;
    logic [ADD_WIDTH-1:0] wrap_mask;
    logic [ADD_WIDTH-1:0] incr_addr;

    assign step_bytes = ADD_WIDTH'(1) << size;
    // Wrap window is (len+1) beats of 2**size bytes, aligned to its own size.
    assign wrap_mask  = ((ADD_WIDTH'(len) + ADD_WIDTH'(1)) << size) - ADD_WIDTH'(1);
    assign incr_addr  = addr + step_bytes;

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // next_addr unassigned, which would infer a latch.
        next_addr = incr_addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/data_write.sv
// data_write: write-data path of the slave. Takes a burst command from the
// write-address module, accepts the W beats, issues one memory write per
// beat, then returns a single B response.
//   clk, reset                       clock, asynchronous active-low reset
//   wid/wdata/wstrb/wlast/wvalid/wready   W channel
//   bid/bresp/bvalid/bready          B channel
//   waddr_in/wlen_in/wsize_in/wburst_in/wid_in, mod1_valid_in/mod1_ready_out
//                                    command from the write-address module
//   mem_we/mem_addr/mem_wdata/mem_be memory write port, one cycle per beat
module data_write
    import data_write_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADD_ID_WIDTH-1:0] wid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [STRB_WIDTH-1:0]   wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ADD_ID_WIDTH-1:0] bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADD_WIDTH-1:0]    waddr_in,
    input  logic [BURST_LEN-1:0]    wlen_in,
    input  logic [BURST_SIZE-1:0]   wsize_in,
    input  logic [BURST_TYPE-1:0]   wburst_in,
    input  logic [ADD_ID_WIDTH-1:0] wid_in,
    input  logic                    mod1_valid_in,
    output logic                    mod1_ready_out,
    output logic                    mem_we,
    output logic [ADD_WIDTH-1:0]    mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [STRB_WIDTH-1:0]   mem_be
);

    state_t                  state;
    logic [ADD_WIDTH-1:0]    addr;
    logic [ADD_WIDTH-1:0]    next_addr;
    logic [BURST_LEN-1:0]    len;
    logic [BURST_SIZE-1:0]   size;
    logic [BURST_TYPE-1:0]   burst;
    logic [ADD_ID_WIDTH-1:0] id;
    logic [BURST_LEN:0]      count;     // holds up to 2**BURST_LEN beats
    logic                    err;

    logic beat;
    logic final_beat;
    logic beat_err;

    burst_addr_gen u_addr_gen (
        .addr      (addr),
        .len       (len),
        .size      (size),
        .burst     (burst),
        .next_addr (next_addr)
    );

    assign beat       = (state == S_DATA) && wvalid && wready;
    assign final_beat = (count == (BURST_LEN+1)'(1));
    // wlast must agree with the beat count, and every beat must carry the
    // captured ID; the count alone terminates the burst.
    assign beat_err   = (wid != id) || (wlast != final_beat);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            addr           <= '0;
            len            <= '0;
            size           <= '0;
            burst          <= '0;
            id             <= '0;
            count          <= '0;
            err            <= 1'b0;
            wready         <= 1'b0;
            bvalid         <= 1'b0;
            bid            <= '0;
            bresp          <= RESP_OKAY;
            mod1_ready_out <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_be         <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so a later assignment
            // in this block overrides this default and every read sees the
            // pre-edge value.
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    mod1_ready_out <= 1'b1;
                    if (mod1_valid_in && mod1_ready_out) begin
                        addr           <= waddr_in;
                        len            <= wlen_in;
                        size           <= wsize_in;
                        burst          <= wburst_in;
                        id             <= wid_in;
                        count          <= (BURST_LEN+1)'(wlen_in) + (BURST_LEN+1)'(1);
                        err            <= (wburst_in == BURST_RSVD);
                        mod1_ready_out <= 1'b0;
                        wready         <= 1'b1;
                        state          <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (beat) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= wdata;
                        mem_be    <= wstrb & lane_mask(addr[LANE_W-1:0], size);
                        addr      <= next_addr;
                        count     <= count - (BURST_LEN+1)'(1);
                        err       <= err | beat_err;
                        if (final_beat) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bid    <= id;
                            bresp  <= (err | beat_err) ? RESP_SLVERR : RESP_OKAY;
                            state  <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (bready) begin
                        bvalid         <= 1'b0;
                        mod1_ready_out <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_write.sv
// Directed self-checking bench for data_write: reset values, INCR / WRAP /
// FIXED bursts, reserved burst type, wlast misuse, single-beat burst, B
// back-pressure, W traffic outside DATA, and reset in the middle of a burst.
module tb_data_write;
    import data_write_pkg::*;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [ADD_ID_WIDTH-1:0] wid;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [STRB_WIDTH-1:0]   wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ADD_ID_WIDTH-1:0] bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADD_WIDTH-1:0]    waddr_in;
    logic [BURST_LEN-1:0]    wlen_in;
    logic [BURST_SIZE-1:0]   wsize_in;
    logic [BURST_TYPE-1:0]   wburst_in;
    logic [ADD_ID_WIDTH-1:0] wid_in;
    logic                    mod1_valid_in;
    logic                    mod1_ready_out;
    logic                    mem_we;
    logic [ADD_WIDTH-1:0]    mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [STRB_WIDTH-1:0]   mem_be;

    int checks = 0;
    int errors = 0;

    data_write dut (
        .clk            (clk),
        .reset          (reset),
        .wid            (wid),
        .wdata          (wdata),
        .wstrb          (wstrb),
        .wlast          (wlast),
        .wvalid         (wvalid),
        .wready         (wready),
        .bid            (bid),
        .bresp          (bresp),
        .bvalid         (bvalid),
        .bready         (bready),
        .waddr_in       (waddr_in),
        .wlen_in        (wlen_in),
        .wsize_in       (wsize_in),
        .wburst_in      (wburst_in),
        .wid_in         (wid_in),
        .mod1_valid_in  (mod1_valid_in),
        .mod1_ready_out (mod1_ready_out),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_be         (mem_be)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input string tag, input logic [31:0] a, input logic [7:0] l,
                            input logic [2:0] s, input logic [1:0] b, input logic [3:0] i);
        int n = 0;
        while (!mod1_ready_out && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_cmd_ready"}, mod1_ready_out, 1);
        waddr_in = a; wlen_in = l; wsize_in = s; wburst_in = b; wid_in = i;
        mod1_valid_in = 1'b1;
        step();
        mod1_valid_in = 1'b0;
        chk({tag, "_wready_up"}, wready, 1);
        chk({tag, "_cmd_ready_down"}, mod1_ready_out, 0);
    endtask

    task automatic beat(input string tag, input logic [31:0] d, input logic [3:0] st,
                        input logic l, input logic [3:0] i,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be);
        wdata = d; wstrb = st; wlast = l; wid = i; wvalid = 1'b1;
        step();
        chk({tag, "_we"}, mem_we, 1);
        chk({tag, "_addr"}, mem_addr, exp_addr);
        chk({tag, "_be"}, mem_be, exp_be);
        chk({tag, "_data"}, mem_wdata, d);
    endtask

    // Called right after the final beat; wvalid is still high from it.
    task automatic finish_burst(input string tag, input logic [3:0] exp_id,
                                input logic [1:0] exp_resp, input int hold);
        chk({tag, "_bvalid"}, bvalid, 1);
        chk({tag, "_bid"}, bid, exp_id);
        chk({tag, "_bresp"}, bresp, exp_resp);
        chk({tag, "_wready_down"}, wready, 0);
        wdata = 32'hDEAD_BEEF;
        step();
        chk({tag, "_resp_no_write"}, mem_we, 0);
        wvalid = 1'b0;
        for (int k = 0; k < hold; k++) begin
            step();
            chk({tag, "_hold_bvalid"}, bvalid, 1);
            chk({tag, "_hold_bid"}, bid, exp_id);
            chk({tag, "_hold_bresp"}, bresp, exp_resp);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk({tag, "_bvalid_down"}, bvalid, 0);
        chk({tag, "_idle_ready"}, mod1_ready_out, 1);
    endtask

    initial begin
        reset = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        waddr_in = '0; wlen_in = '0; wsize_in = '0; wburst_in = '0; wid_in = '0;
        mod1_valid_in = 1'b0;
        repeat (3) step();
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_bid", bid, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mod1_ready", mod1_ready_out, 0);

        reset = 1'b1;
        step();
        chk("post_rst_mod1_ready", mod1_ready_out, 1);
        chk("post_rst_wready", wready, 0);

        // W traffic in IDLE is ignored.
        wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF; wlast = 1'b1;
        step();
        chk("idle_no_write", mem_we, 0);
        wvalid = 1'b0;

        // INCR 0x100, 4 beats of 4 bytes.
        send_cmd("incr", 32'h100, 8'd3, 3'd2, 2'b01, 4'd3);
        beat("incr_b0", 32'hA000_0000, 4'hF, 1'b0, 4'd3, 32'h100, 4'hF);
        beat("incr_b1", 32'hA000_0001, 4'hF, 1'b0, 4'd3, 32'h104, 4'hF);
        beat("incr_b2", 32'hA000_0002, 4'hF, 1'b0, 4'd3, 32'h108, 4'hF);
        beat("incr_b3", 32'hA000_0003, 4'hF, 1'b1, 4'd3, 32'h10C, 4'hF);
        finish_burst("incr", 4'd3, 2'b00, 0);

        // WRAP 0x108 within a 16-byte window.
        send_cmd("wrap", 32'h108, 8'd3, 3'd2, 2'b10, 4'd5);
        beat("wrap_b0", 32'hB000_0000, 4'hF, 1'b0, 4'd5, 32'h108, 4'hF);
        beat("wrap_b1", 32'hB000_0001, 4'hF, 1'b0, 4'd5, 32'h10C, 4'hF);
        beat("wrap_b2", 32'hB000_0002, 4'hF, 1'b0, 4'd5, 32'h100, 4'hF);
        beat("wrap_b3", 32'hB000_0003, 4'hF, 1'b1, 4'd5, 32'h104, 4'hF);
        finish_burst("wrap", 4'd5, 2'b00, 0);

        // FIXED 0x20, byte-sized beats: only lane 0 enabled.
        send_cmd("fixed", 32'h20, 8'd1, 3'd0, 2'b00, 4'd1);
        beat("fixed_b0", 32'hC000_0000, 4'hF, 1'b0, 4'd1, 32'h20, 4'h1);
        beat("fixed_b1", 32'hC000_0001, 4'hF, 1'b1, 4'd1, 32'h20, 4'h1);
        finish_burst("fixed", 4'd1, 2'b00, 0);

        // Early wlast on beat 2 of 3: all three beats written, SLVERR,
        // and B held against bready low for five cycles.
        send_cmd("early", 32'h40, 8'd2, 3'd2, 2'b01, 4'd9);
        beat("early_b0", 32'hD000_0000, 4'hF, 1'b0, 4'd9, 32'h40, 4'hF);
        beat("early_b1", 32'hD000_0001, 4'hF, 1'b1, 4'd9, 32'h44, 4'hF);
        beat("early_b2", 32'hD000_0002, 4'hF, 1'b1, 4'd9, 32'h48, 4'hF);
        finish_burst("early", 4'd9, 2'b10, 5);

        // Single-beat halfword at lane offset 2.
        send_cmd("single", 32'h46, 8'd0, 3'd1, 2'b01, 4'd7);
        beat("single_b0", 32'hE000_0000, 4'hF, 1'b1, 4'd7, 32'h46, 4'hC);
        finish_burst("single", 4'd7, 2'b00, 0);

        // Reserved burst type: incrementing addresses, SLVERR.
        send_cmd("rsvd", 32'h10, 8'd1, 3'd2, 2'b11, 4'd4);
        beat("rsvd_b0", 32'hF000_0000, 4'hF, 1'b0, 4'd4, 32'h10, 4'hF);
        beat("rsvd_b1", 32'hF000_0001, 4'hF, 1'b1, 4'd4, 32'h14, 4'hF);
        finish_burst("rsvd", 4'd4, 2'b10, 0);

        // Wrong wid on the only beat: SLVERR.
        send_cmd("badid", 32'h80, 8'd0, 3'd2, 2'b01, 4'd2);
        beat("badid_b0", 32'h1111_2222, 4'hF, 1'b1, 4'd3, 32'h80, 4'hF);
        finish_burst("badid", 4'd2, 2'b10, 0);

        // Reset after beat 2 of an 8-beat burst.
        send_cmd("mid", 32'h200, 8'd7, 3'd2, 2'b01, 4'd2);
        beat("mid_b0", 32'h2000_0000, 4'hF, 1'b0, 4'd2, 32'h200, 4'hF);
        beat("mid_b1", 32'h2000_0001, 4'hF, 1'b0, 4'd2, 32'h204, 4'hF);
        reset = 1'b0;
        #1;
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wready", wready, 0);
        chk("mid_rst_mod1_ready", mod1_ready_out, 0);
        chk("mid_rst_bvalid", bvalid, 0);
        wvalid = 1'b0;
        reset = 1'b1;
        step();
        chk("mid_post_ready", mod1_ready_out, 1);
        repeat (2) step();
        chk("mid_no_bvalid", bvalid, 0);
        send_cmd("after", 32'h300, 8'd0, 3'd2, 2'b01, 4'd6);
        beat("after_b0", 32'h3000_0000, 4'hF, 1'b1, 4'd6, 32'h300, 4'hF);
        finish_burst("after", 4'd6, 2'b00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
